// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, instruction field positions, special registers
// and field-extraction helpers for the 32-bit instruction format.
package proc_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam int OPC_LO = 27;
    localparam int RD_LO  = 22;
    localparam int RS_LO  = 17;
    localparam int RT_LO  = 12;
    localparam int IMM_W  = 17;
    localparam int TGT_W  = 27;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [4:0] REG_STATUS = 5'd30;
    localparam logic [4:0] REG_RA     = 5'd31;

    function automatic logic [4:0] insn_op(input logic [31:0] insn);
        return insn[OPC_LO +: 5];
    endfunction

    function automatic logic [4:0] insn_rd(input logic [31:0] insn);
        return insn[RD_LO +: 5];
    endfunction

    function automatic logic [4:0] insn_rs(input logic [31:0] insn);
        return insn[RS_LO +: 5];
    endfunction

    function automatic logic [4:0] insn_rt(input logic [31:0] insn);
        return insn[RT_LO +: 5];
    endfunction

endpackage

// File: rtl/decode_regsel.sv
// Combinational opcode -> register-file read address (A, B) selection.
module decode_regsel
    import proc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             valid_i,
    input  logic [WIDTH-1:0] insn_i,
    output logic [REGW-1:0]  ra_o,
    output logic [REGW-1:0]  rb_o
);

    logic [31:0] insn;
    logic [4:0]  rd, rs, rt;

    assign insn = insn_i[31:0];
    assign rd   = insn_rd(insn);
    assign rs   = insn_rs(insn);
    assign rt   = insn_rt(insn);

    // Low immediate bits never steer the read ports.
    logic unused_bits;
    assign unused_bits = ^insn[11:0];

    always_comb begin
        ra_o = '0;
        rb_o = '0;
        if (valid_i) begin
            case (insn_op(insn))
                OP_RTYPE:        begin ra_o = REGW'(rs);         rb_o = REGW'(rt); end
                OP_ADDI, OP_LW:  begin ra_o = REGW'(rs);         rb_o = '0;        end
                OP_SW:           begin ra_o = REGW'(rs);         rb_o = REGW'(rd); end
                OP_BNE, OP_BLT:  begin ra_o = REGW'(rd);         rb_o = REGW'(rs); end
                OP_JR:           begin ra_o = REGW'(rd);         rb_o = '0;        end
                OP_BEX:          begin ra_o = REGW'(REG_STATUS); rb_o = '0;        end
                default:         begin ra_o = '0;                rb_o = '0;        end
            endcase
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: regfile address select, load-use hazard, flush/stall, D/X latch.
// Optional W->D operand bypass enabled by defining DECODE_WD_BYPASS_EN.
module decode_stage
    import proc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             fd_valid,
    input  logic [WIDTH-1:0] fd_pc,
    input  logic [WIDTH-1:0] fd_insn,
    output logic [REGW-1:0]  ctrl_readRegA,
    output logic [REGW-1:0]  ctrl_readRegB,
    input  logic [WIDTH-1:0] data_readRegA,
    input  logic [WIDTH-1:0] data_readRegB,
    input  logic             w_we,
    input  logic [REGW-1:0]  w_rd,
    input  logic [WIDTH-1:0] w_data,
    input  logic             x_flush,
    input  logic             x_stall,
    output logic             stall_fd,
    output logic             dx_valid,
    output logic [WIDTH-1:0] dx_pc,
    output logic [WIDTH-1:0] dx_insn,
    output logic [WIDTH-1:0] dx_a,
    output logic [WIDTH-1:0] dx_b,
    output logic [WIDTH-1:0] dx_imm,
    output logic [WIDTH-1:0] dx_target
);

    logic             dx_valid_q, dx_valid_d;
    logic [WIDTH-1:0] dx_pc_q, dx_pc_d;
    logic [WIDTH-1:0] dx_insn_q, dx_insn_d;
    logic [WIDTH-1:0] dx_a_q, dx_a_d;
    logic [WIDTH-1:0] dx_b_q, dx_b_d;
    logic [WIDTH-1:0] dx_imm_q, dx_imm_d;
    logic [WIDTH-1:0] dx_target_q, dx_target_d;

    logic [REGW-1:0]  ra, rb;
    logic [WIDTH-1:0] opa, opb;
    logic [4:0]       dx_op, dx_rd;
    logic             hazard;

    decode_regsel #(.WIDTH(WIDTH), .REGW(REGW)) u_regsel (
        .valid_i (fd_valid),
        .insn_i  (fd_insn),
        .ra_o    (ra),
        .rb_o    (rb)
    );

    assign ctrl_readRegA = ra;
    assign ctrl_readRegB = rb;

    assign dx_op  = insn_op(dx_insn_q[31:0]);
    assign dx_rd  = insn_rd(dx_insn_q[31:0]);
    assign hazard = dx_valid_q && (dx_op == OP_LW) && (dx_rd != REG_ZERO) &&
                    ((REGW'(dx_rd) == ra) || (REGW'(dx_rd) == rb)) && fd_valid;
    assign stall_fd = hazard || x_stall;

    // Operand capture; register 0 is forced to zero after any bypass.
    always_comb begin
        opa = data_readRegA;
        opb = data_readRegB;
`ifdef DECODE_WD_BYPASS_EN
        if (w_we && (w_rd != '0) && (w_rd == ra)) opa = w_data;
        if (w_we && (w_rd != '0) && (w_rd == rb)) opb = w_data;
`endif
        if (ra == '0) opa = '0;
        if (rb == '0) opb = '0;
    end

`ifndef DECODE_WD_BYPASS_EN
    logic unused_wb;
    assign unused_wb = w_we ^ (^w_rd) ^ (^w_data);
`endif

    always_comb begin
        dx_valid_d  = dx_valid_q;
        dx_pc_d     = dx_pc_q;
        dx_insn_d   = dx_insn_q;
        dx_a_d      = dx_a_q;
        dx_b_d      = dx_b_q;
        dx_imm_d    = dx_imm_q;
        dx_target_d = dx_target_q;
        if (x_flush) begin
            dx_valid_d = 1'b0;
        end else if (x_stall) begin
            dx_valid_d = dx_valid_q;
        end else if (hazard) begin
            dx_valid_d = 1'b0;
            dx_insn_d  = '0;
        end else begin
            dx_valid_d  = fd_valid;
            dx_pc_d     = fd_pc;
            dx_insn_d   = fd_insn;
            dx_a_d      = opa;
            dx_b_d      = opb;
            dx_imm_d    = {{(WIDTH-IMM_W){fd_insn[IMM_W-1]}}, fd_insn[IMM_W-1:0]};
            dx_target_d = {{(WIDTH-TGT_W){1'b0}}, fd_insn[TGT_W-1:0]};
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            dx_valid_q  <= 1'b0;
            dx_pc_q     <= '0;
            dx_insn_q   <= '0;
            dx_a_q      <= '0;
            dx_b_q      <= '0;
            dx_imm_q    <= '0;
            dx_target_q <= '0;
        end else begin
            dx_valid_q  <= dx_valid_d;
            dx_pc_q     <= dx_pc_d;
            dx_insn_q   <= dx_insn_d;
            dx_a_q      <= dx_a_d;
            dx_b_q      <= dx_b_d;
            dx_imm_q    <= dx_imm_d;
            dx_target_q <= dx_target_d;
        end
    end

    assign dx_valid  = dx_valid_q;
    assign dx_pc     = dx_pc_q;
    assign dx_insn   = dx_insn_q;
    assign dx_a      = dx_a_q;
    assign dx_b      = dx_b_q;
    assign dx_imm    = dx_imm_q;
    assign dx_target = dx_target_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected D/X state, monitor checks it.
module tb_decode_stage;
    import proc_pkg::*;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        fd_valid;
    logic [31:0] fd_pc, fd_insn;
    logic [4:0]  ctrl_readRegA, ctrl_readRegB;
    logic [31:0] data_readRegA, data_readRegB;
    logic        w_we;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic        x_flush, x_stall, stall_fd;
    logic        dx_valid;
    logic [31:0] dx_pc, dx_insn, dx_a, dx_b, dx_imm, dx_target;

    logic [31:0] rf [32];

    int total = 0;
    int bad   = 0;

    // mode 0: valid only, 1: valid+insn, 2: every field
    typedef struct {
        int          mode;
        logic        v;
        logic [31:0] pc, insn, a, b, imm, tgt;
        int          id;
    } exp_t;

    exp_t q[$];
    exp_t last;

    always #5 clock = ~clock;

    assign data_readRegA = rf[ctrl_readRegA];
    assign data_readRegB = rf[ctrl_readRegB];

    decode_stage #(.WIDTH(32), .REGW(5)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .fd_valid(fd_valid), .fd_pc(fd_pc), .fd_insn(fd_insn),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
        .w_we(w_we), .w_rd(w_rd), .w_data(w_data),
        .x_flush(x_flush), .x_stall(x_stall), .stall_fd(stall_fd),
        .dx_valid(dx_valid), .dx_pc(dx_pc), .dx_insn(dx_insn),
        .dx_a(dx_a), .dx_b(dx_b), .dx_imm(dx_imm), .dx_target(dx_target)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] op, rd, rs, rt);
        return {op, rd, rs, rt, 12'b0};
    endfunction
    function automatic logic [31:0] enc_i(input logic [4:0] op, rd, rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic push_load(input logic [31:0] ea, input logic [31:0] eb, input int id);
        exp_t e;
        e.mode = 2; e.v = 1'b1; e.pc = fd_pc; e.insn = fd_insn; e.a = ea; e.b = eb;
        e.imm = {{15{fd_insn[16]}}, fd_insn[16:0]};
        e.tgt = {5'b0, fd_insn[26:0]};
        e.id = id;
        last = e;
        q.push_back(e);
    endtask

    task automatic push_mode(input int mode, input int id);
        exp_t e;
        e = '{mode: mode, v: 1'b0, pc: 0, insn: 0, a: 0, b: 0, imm: 0, tgt: 0, id: id};
        q.push_back(e);
    endtask

    task automatic push_hold(input int id);
        exp_t e;
        e = last;
        e.id = id;
        q.push_back(e);
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] insn);
        fd_valid = v; fd_pc = pc; fd_insn = insn;
        #1;
    endtask

    // Monitor: one scoreboard entry per clock edge, checked just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk($sformatf("dx_valid#%0d", e.id), {31'b0, dx_valid}, {31'b0, e.v});
                if (e.mode >= 1) chk($sformatf("dx_insn#%0d", e.id), dx_insn, e.insn);
                if (e.mode == 2) begin
                    chk($sformatf("dx_pc#%0d", e.id), dx_pc, e.pc);
                    chk($sformatf("dx_a#%0d", e.id), dx_a, e.a);
                    chk($sformatf("dx_b#%0d", e.id), dx_b, e.b);
                    chk($sformatf("dx_imm#%0d", e.id), dx_imm, e.imm);
                    chk($sformatf("dx_target#%0d", e.id), dx_target, e.tgt);
                end
            end
        end
    end

    initial begin
        logic [31:0] bypass_exp;
        int waits;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[0] = 32'h0000_0BAD;
        rf[1] = 32'd5;  rf[2] = 32'd7;  rf[4] = 32'd40; rf[5] = 32'd55;
        rf[6] = 32'd60; rf[30] = 32'd300;
        w_we = 1'b0; w_rd = 5'd0; w_data = 32'h0;
        x_flush = 1'b0; x_stall = 1'b0;

        // Reset for two edges with a valid F/D instruction present
        ctrl_reset = 1'b0;
        drive(1'b1, 32'h100, enc_r(OP_RTYPE, 5'd3, 5'd1, 5'd2));
        push_mode(2, 1);
        tick;
        drive(1'b1, 32'h100, enc_r(OP_RTYPE, 5'd3, 5'd1, 5'd2));
        chk("stall_fd_rst", {31'b0, stall_fd}, 32'd0);
        push_mode(2, 2);
        tick;

        // add r3,r1,r2
        ctrl_reset = 1'b1;
        drive(1'b1, 32'h100, enc_r(OP_RTYPE, 5'd3, 5'd1, 5'd2));
        chk("rA_add", {27'b0, ctrl_readRegA}, 32'd1);
        chk("rB_add", {27'b0, ctrl_readRegB}, 32'd2);
        push_load(32'd5, 32'd7, 3);
        tick;

        // bne r4,r6 -> (rd, rs)
        drive(1'b1, 32'h104, enc_i(OP_BNE, 5'd4, 5'd6, 17'h00010));
        chk("rA_bne", {27'b0, ctrl_readRegA}, 32'd4);
        chk("rB_bne", {27'b0, ctrl_readRegB}, 32'd6);
        push_load(32'd40, 32'd60, 4);
        tick;

        // bex -> (30, 0)
        drive(1'b1, 32'h108, {OP_BEX, 27'h0000123});
        chk("rA_bex", {27'b0, ctrl_readRegA}, 32'd30);
        chk("rB_bex", {27'b0, ctrl_readRegB}, 32'd0);
        push_load(32'd300, 32'd0, 5);
        tick;

        // Load-use: lw r5,0(r1) then add r6,r5,r2
        drive(1'b1, 32'h10c, enc_i(OP_LW, 5'd5, 5'd1, 17'h0));
        chk("stall_lw", {31'b0, stall_fd}, 32'd0);
        push_load(32'd5, 32'd0, 6);
        tick;
        drive(1'b1, 32'h110, enc_r(OP_RTYPE, 5'd6, 5'd5, 5'd2));
        chk("stall_hz", {31'b0, stall_fd}, 32'd1);
        push_mode(1, 7);
        tick;
        drive(1'b1, 32'h110, enc_r(OP_RTYPE, 5'd6, 5'd5, 5'd2));
        chk("stall_hz_end", {31'b0, stall_fd}, 32'd0);
        push_load(32'd55, 32'd7, 8);
        tick;

        // Flush wins over stall and hazard
        drive(1'b1, 32'h114, enc_i(OP_LW, 5'd5, 5'd1, 17'h0));
        push_load(32'd5, 32'd0, 9);
        tick;
        x_flush = 1'b1; x_stall = 1'b1;
        drive(1'b1, 32'h118, enc_r(OP_RTYPE, 5'd6, 5'd5, 5'd2));
        chk("stall_fl", {31'b0, stall_fd}, 32'd1);
        push_mode(0, 10);
        tick;
        x_flush = 1'b0; x_stall = 1'b0;
        drive(1'b1, 32'h11c, enc_i(OP_ADDI, 5'd9, 5'd2, 17'h00010));
        push_load(32'd7, 32'd0, 11);
        tick;

        // x_stall holds D/X for 3 cycles while F/D shows a sw
        x_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h120, enc_i(OP_SW, 5'd2, 5'd1, 17'h00008));
            chk("stall_x", {31'b0, stall_fd}, 32'd1);
            push_hold(12 + i);
            tick;
        end
        x_stall = 1'b0;
        drive(1'b1, 32'h120, enc_i(OP_SW, 5'd2, 5'd1, 17'h00008));
        chk("rA_sw", {27'b0, ctrl_readRegA}, 32'd1);
        chk("rB_sw", {27'b0, ctrl_readRegB}, 32'd2);
        push_load(32'd5, 32'd7, 15);
        tick;

        // lw to r0 never stalls; r0 reads as zero despite regfile content
        drive(1'b1, 32'h124, enc_i(OP_LW, 5'd0, 5'd1, 17'h0));
        push_load(32'd5, 32'd0, 16);
        tick;
        drive(1'b1, 32'h128, enc_r(OP_RTYPE, 5'd6, 5'd0, 5'd2));
        chk("stall_r0", {31'b0, stall_fd}, 32'd0);
        push_load(32'd0, 32'd7, 17);
        tick;

        // Invalid F/D: addresses 0, bubble latched
        drive(1'b0, 32'h12c, enc_r(OP_RTYPE, 5'd3, 5'd1, 5'd2));
        chk("rA_inv", {27'b0, ctrl_readRegA}, 32'd0);
        push_mode(0, 18);
        tick;

        // W->D bypass
        rf[1] = 32'd0;
        w_we = 1'b1; w_rd = 5'd1; w_data = 32'hDEADBEEF;
`ifdef DECODE_WD_BYPASS_EN
        bypass_exp = 32'hDEADBEEF;
`else
        bypass_exp = 32'h0;
`endif
        drive(1'b1, 32'h130, enc_i(OP_ADDI, 5'd2, 5'd1, 17'h4));
        push_load(bypass_exp, 32'd0, 19);
        tick;
        w_rd = 5'd0;
        drive(1'b1, 32'h134, enc_i(OP_ADDI, 5'd2, 5'd1, 17'h4));
        push_load(32'd0, 32'd0, 20);
        tick;
        w_we = 1'b0;

        // Immediate / target extension
        drive(1'b1, 32'h138, enc_i(OP_ADDI, 5'd1, 5'd1, 17'h1FFFF));
        push_load(32'd0, 32'd0, 21);
        tick;
        drive(1'b1, 32'h13c, {OP_J, 27'h4000000});
        chk("imm_sext", dx_imm, 32'hFFFFFFFF);
        push_load(32'd0, 32'd0, 22);
        tick;
        drive(1'b1, 32'h140, enc_r(OP_RTYPE, 5'd3, 5'd1, 5'd2));
        chk("target_zext", dx_target, 32'h04000000);

        // Reset during a stall clears everything
        x_stall = 1'b1; ctrl_reset = 1'b0;
        push_mode(2, 23);
        tick;
        x_stall = 1'b0;
        drive(1'b1, 32'h140, enc_r(OP_RTYPE, 5'd3, 5'd1, 5'd2));
        chk("stall_rst2", {31'b0, stall_fd}, 32'd0);
        push_mode(2, 24);
        tick;
        ctrl_reset = 1'b1;
        rf[1] = 32'd5;
        drive(1'b1, 32'h144, enc_r(OP_RTYPE, 5'd3, 5'd1, 5'd2));
        push_load(32'd5, 32'd7, 25);
        tick;

        waits = 0;
        while (q.size() > 0 && waits < 10) begin
            tick;
            waits++;
        end
        if (q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode stage of the 5-stage pipeline; sits directly upstream of the register file.
- Selects the regfile read addresses from the F/D instruction.
- Captures the read data, with an optional W->D bypass, into the D/X pipeline latch.
- Owns load-use hazard detection, bubble insertion, flush and downstream-stall hold.

Parameters:
- WIDTH, 32, datapath/instruction width
- REGW, 5, register-index width

Ports:
- clock  in  1  single clock; all state updates on rising edge
- ctrl_reset  in  1  synchronous, active-low reset (0 = reset at the next rising edge)
- fd_valid  in  1  F/D latch holds a real instruction
- fd_pc  in  WIDTH  PC of the F/D instruction
- fd_insn  in  WIDTH  F/D instruction
- ctrl_readRegA  out  REGW  regfile port A address (combinational)
- ctrl_readRegB  out  REGW  regfile port B address (combinational)
- data_readRegA  in  WIDTH  regfile port A data
- data_readRegB  in  WIDTH  regfile port B data
- w_we  in  1  writeback write enable (same signal as regfile ctrl_writeEnable)
- w_rd  in  REGW  writeback destination
- w_data  in  WIDTH  writeback data
- x_flush  in  1  taken branch/jump resolved in X; kill the D instruction
- x_stall  in  1  X busy (multdiv); hold the D/X latch
- stall_fd  out  1  hold PC and the F/D latch (combinational)
- dx_valid  out  1  D/X latch valid
- dx_pc, dx_insn, dx_a, dx_b  out  WIDTH each  latched PC, instruction, operand A, operand B
- dx_imm  out  WIDTH  sign-extended insn[16:0]
- dx_target  out  WIDTH  zero-extended insn[26:0]

Behaviour:
- Instruction fields: opcode[31:27], rd[26:22], rs[21:17], rt[16:12].
- Register select (A, B) by opcode:
  - 00000 R-type: (rs, rt)
  - 00101 addi, 01000 lw: (rs, 0)
  - 00111 sw: (rs, rd)
  - 00010 bne, 00110 blt: (rd, rs)
  - 00100 jr: (rd, 0)
  - 10110 bex: (30, 0)
  - all other opcodes, or fd_valid=0: (0, 0)
- Load-use hazard = dx_valid & dx opcode==01000 & dx rd!=0 & (dx rd==A or dx rd==B) & fd_valid.
- stall_fd = hazard | x_stall.
- D/X update priority at each rising edge:
  1. ctrl_reset=0: all dx_* cleared to 0; dx_valid=0.
  2. x_flush=1: dx_valid<=0; other dx_* don't-care. Overrides x_stall and hazard.
  3. x_stall=1: all dx_* hold.
  4. hazard: bubble; dx_valid<=0, dx_insn<=0.
  5. otherwise load: dx_valid<=fd_valid and the remaining fields from the F/D inputs.
- Latency: exactly 1 cycle F/D->D/X when unstalled.
- Reset values: every dx_* output is 0. stall_fd and ctrl_readReg* are combinational and follow their inputs; with dx_valid=0 and x_stall=0, stall_fd=0.
- Register 0 always reads as 0 in dx_a/dx_b, including through the bypass.
- Reset asserted mid-stall or mid-hazard clears all state; there is no pending-state carry-over.

Optional Feature:
- Macro: DECODE_WD_BYPASS_EN.
- Defined: if w_we & w_rd!=0 & w_rd==A, then dx_a captures w_data instead of data_readRegA. The same rule applies to B.
- Not defined: dx_a/dx_b capture regfile data only. Software must separate a W-stage write from a dependent D-stage read by at least one instruction.

Decomposition:
- Shared package proc_pkg: opcode constants (OP_RTYPE, OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT, OP_JR, OP_BEX, OP_SETX, OP_J, OP_JAL), field bit-position constants, REG_STATUS=30, REG_RA=31.
- One sub-module: decode_regsel, the combinational opcode-to-(A, B) address select, reused by hazard logic in later stages.

Test Plan:
- Reset: hold ctrl_reset=0 for 2 cycles with fd_valid=1 -> all dx_*=0 and stall_fd=0. Release -> the next edge loads F/D.
- Select: add r3,r1,r2 with r1=5, r2=7 -> ctrl_readRegA=1, ctrl_readRegB=2; next cycle dx_a=5, dx_b=7, dx_valid=1. bne r4,r6 -> A=4, B=6. bex -> A=30.
- Load-use: lw r5,0(r1) in D/X, then add r6,r5,r2 in F/D -> stall_fd=1 for 1 cycle, one bubble (dx_valid=0). The add then enters D/X.
- Flush priority: x_flush=1 with x_stall=1 and a hazard present -> next edge dx_valid=0. Then x_stall=1 alone -> dx_* unchanged for 3 cycles.
- Bypass (macro on): w_we=1, w_rd=1, w_data=0xDEADBEEF with regfile r1=0, decoding addi r2,r1,4 -> dx_a=0xDEADBEEF. Same stimulus with w_rd=0 -> dx_a=0. Macro off -> dx_a=0.
- Immediate: addi with imm=0x1FFFF -> dx_imm=0xFFFFFFFF. j with target 0x4000000 -> dx_target=0x04000000.
